// File: rtl/ball_motion.sv
// ----------------------------------------------------------------------------
// ball_motion
//
// Frame-rate ball position controller. Once per VGA vertical-sync rising edge
// it decodes a pair of USB HID usage codes into a motion vector, reflects that
// vector off the screen edges, and steps the ball centre by it.
//
// Ports:
//   Clk        : system clock; all state changes on its rising edge
//   Reset      : asynchronous, active-high reset
//   frame_clk  : VGA vertical sync, asynchronous to Clk (rising edge used)
//   keycode    : {key2, key1} HID usage codes, 0x00 = no key
//   BallX      : ball centre X (unsigned)
//   BallY      : ball centre Y (unsigned)
//   BallS      : ball half-size (constant SIZE)
//   frame_tick : one-Clk pulse marking each position update
// ----------------------------------------------------------------------------
module ball_motion #(
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 1,
  parameter int SIZE     = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  BallS,
  output logic        frame_tick
);

  localparam logic signed [9:0] STEP_POS = 10'(STEP);
  localparam logic signed [9:0] STEP_NEG = 10'(-STEP);

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  logic              s1;
  logic              s2;
  logic              s_prev;
  logic signed [9:0] mot_x;
  logic signed [9:0] mot_y;
  logic signed [9:0] des_x;
  logic signed [9:0] des_y;
  logic signed [9:0] mot_x_next;
  logic signed [9:0] mot_y_next;
  logic [7:0]        key_sel;
  logic [10:0]       x_far;
  logic [10:0]       y_far;
  logic              at_x_max;
  logic              at_x_min;
  logic              at_y_max;
  logic              at_y_min;

  function automatic logic is_move(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_S) || (code == KEY_A) || (code == KEY_D);
  endfunction

  assign BallS = 10'(SIZE);

  // frame_tick depends only on flops, so it carries no combinational path
  // from frame_clk. Clearing the synchronizer on reset means a frame_clk
  // that is already high at release shows up as at most one clean rise.
  assign frame_tick = s2 & ~s_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= frame_clk;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  // The high byte is consulted only when the low byte is not a movement key,
  // so a non-movement high byte falls through to "keep current motion".
  always_comb begin
    des_x   = mot_x;
    des_y   = mot_y;
    key_sel = is_move(keycode[7:0]) ? keycode[7:0] : keycode[15:8];
    case (key_sel)
      KEY_W: begin des_x = 10'sd0;  des_y = STEP_NEG; end
      KEY_S: begin des_x = 10'sd0;  des_y = STEP_POS; end
      KEY_A: begin des_x = STEP_NEG; des_y = 10'sd0;  end
      KEY_D: begin des_x = STEP_POS; des_y = 10'sd0;  end
      default: ;
    endcase
  end

  // Edge tests are done in 11 bits so position + size cannot wrap. A wall
  // only reverses motion heading into it; moving away is left alone.
  always_comb begin
    x_far    = {1'b0, BallX} + {1'b0, BallS};
    y_far    = {1'b0, BallY} + {1'b0, BallS};
    at_x_max = x_far >= 11'(X_MAX);
    at_y_max = y_far >= 11'(Y_MAX);
    at_x_min = {1'b0, BallX} <= (11'(X_MIN) + {1'b0, BallS});
    at_y_min = {1'b0, BallY} <= (11'(Y_MIN) + {1'b0, BallS});

    mot_x_next = des_x;
    if (at_x_max && (des_x > 10'sd0)) begin
      mot_x_next = STEP_NEG;
    end else if (at_x_min && (des_x < 10'sd0)) begin
      mot_x_next = STEP_POS;
    end

    mot_y_next = des_y;
    if (at_y_max && (des_y > 10'sd0)) begin
      mot_y_next = STEP_NEG;
    end else if (at_y_min && (des_y < 10'sd0)) begin
      mot_y_next = STEP_POS;
    end
  end

  // Position and motion load together, only on the tick cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BallX <= 10'(X_CENTER);
      BallY <= 10'(Y_CENTER);
      mot_x <= 10'sd0;
      mot_y <= 10'sd0;
    end else if (frame_tick) begin
      BallX <= BallX + mot_x_next;
      BallY <= BallY + mot_y_next;
      mot_x <= mot_x_next;
      mot_y <= mot_y_next;
    end
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Frame-rate ball position controller for the lab 8 USB keyboard demo. It consumes the 16-bit `keycode` that the NIOS II system exports from the CY7C67200 USB host path. On each rising edge of the VGA vertical-sync frame clock, it updates a ball's centre coordinates and size. Its outputs feed the colour-mapping stage that paints the ball into the 640×480 frame.

## Interface
Parameters:
- `X_CENTER`, 320: reset X position.
- `Y_CENTER`, 240: reset Y position.
- `X_MIN`, 0: left bound.
- `X_MAX`, 639: right bound.
- `Y_MIN`, 0: top bound.
- `Y_MAX`, 479: bottom bound.
- `STEP`, 1: pixels moved per frame.
- `SIZE`, 4: ball half-size, driven on `BallS`.

Ports:
- `Clk`, input, 1: 50 MHz system clock (`CLOCK_50`). All state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset (`~KEY[0]` at top level).
- `frame_clk`, input, 1: VGA vertical sync. Asynchronous to `Clk`; only its rising edge is used.
- `keycode`, input, 16: two USB HID usage codes. Low byte is key 1, high byte is key 2. 0x00 means none.
- `BallX`, output, 10: ball centre X, unsigned.
- `BallY`, output, 10: ball centre Y, unsigned.
- `BallS`, output, 10: ball half-size. Constant `SIZE`.
- `frame_tick`, output, 1: one-`Clk` pulse marking each position update, for debug and bench use.

## Operation
- **Frame edge detect.**
  - `frame_clk` passes through a two-flop synchronizer (`s1`, `s2`) and a history flop `s_prev`.
  - `frame_tick = s2 & ~s_prev`.
  - All position and motion registers load only when `frame_tick` = 1. Otherwise they hold.
- **State.** `BallX`, `BallY` (10-bit) and `MotX`, `MotY` (10-bit two's complement, value in {-STEP, 0, +STEP}).
- **Key decode (per tick).**
  - Decode the low byte first. Decode the high byte only if the low byte is not a movement key.
  - 0x1A (W): desired X = 0, desired Y = -STEP.
  - 0x16 (S): desired X = 0, desired Y = +STEP.
  - 0x04 (A): desired X = -STEP, desired Y = 0.
  - 0x07 (D): desired X = +STEP, desired Y = 0.
  - Any other code, including 0x00: desired motion = current `MotX`/`MotY`, so the ball keeps drifting.
- **Wall check (per tick).** Uses the *current* position and the desired motion. The wall override beats the key.
  - If `BallY + BallS >= Y_MAX` and desired Y > 0: `MotY` = -STEP.
  - If `BallY <= Y_MIN + BallS` and desired Y < 0: `MotY` = +STEP.
  - X axis: same rule using `BallX`, `X_MIN`, `X_MAX`.
  - Otherwise the desired value is stored into `MotX`/`MotY`.
- **Position update.** `BallX <= BallX + MotX_next` and `BallY <= BallY + MotY_next`, both modulo 2^10. The wall rule guarantees the result stays in bounds, so no wrap occurs for default parameters.
- **Key held against a wall.** The ball oscillates between two pixels, e.g. Y = 4 and Y = 5. This is required behaviour.
- **Reset.**
  - `BallX` = `X_CENTER`, `BallY` = `Y_CENTER`, `BallS` = `SIZE`.
  - `MotX` = `MotY` = 0, `s1` = `s2` = `s_prev` = 0, `frame_tick` = 0.
  - Takes effect immediately, mid-frame included.
  - A `frame_clk` edge in progress at reset release is either detected cleanly or missed. It never produces a double tick.

## Timing
- **Tick latency.**
  - A `frame_clk` rise sampled at `Clk` edge n is in `s1` at n and in `s2` at n+1.
  - `frame_tick` is high for the cycle between edges n+1 and n+2.
  - `BallX`/`BallY`/`MotX`/`MotY` take their new values at edge n+2.
- **Tick width.** Exactly one `Clk` cycle per `frame_clk` rising edge, regardless of `frame_clk` high time (≥ 2 `Clk` cycles).
- **Keycode sampling.** `keycode` is sampled only at the tick edge. Changes between ticks have no effect.
- **Outputs.** All outputs are registered. There is no combinational path from `keycode` or `frame_clk` to `BallX`/`BallY`.

## Test plan
- **Reset state.** Assert `Reset`, toggle `frame_clk` with `keycode` = 0x0000.
  - Required: `BallX` = 320, `BallY` = 240, `BallS` = 4 throughout.
  - Required: after release, 5 frames with key 0 leave the position unchanged.
- **Right motion and latency.** `keycode` = 0x0007, 10 frames.
  - Required: `BallX` = 330, `BallY` = 240.
  - Required: each update lands 2 `Clk` edges after the first edge sampling `frame_clk` high, with exactly one `frame_tick` per frame.
- **Drift and priority.**
  - Press 0x001A for 3 frames, then 0x0000 for 4 frames. Required: `BallY` = 233, and it is still decrementing.
  - Then 0x0704 (A low, D high). Required: `BallX` decrements, because the low byte wins.
- **Top wall bounce.** From reset, hold 0x001A.
  - Required: `BallY` = 4 after frame 236, then 5 after frame 237, then alternates 4/5.
- **Right wall bounce.** From reset, hold 0x0007.
  - Required: `BallX` = 635 after frame 315, then 634 after frame 316.
- **Reset mid-operation.** Hold 0x0016 for 50 frames, then assert `Reset` asynchronously mid-frame.
  - Required: outputs return to 320/240 within the same `Clk` cycle.
  - Required: after release with key 0x0000, no movement, since motion was cleared.
